// File: rtl/csr_pkg.sv
// Purpose: shared CSR addresses, operation encoding and bit positions for csr_file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package csr_pkg;

    // Machine-mode CSR addresses (instr[31:20])
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    typedef enum logic [1:0] {
        CSR_OP_RW  = 2'b00,
        CSR_OP_RS  = 2'b01,
        CSR_OP_RC  = 2'b10,
        CSR_OP_RSV = 2'b11
    } csr_op_e;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MTIE     = 7;
    localparam int MIP_MTIP     = 7;

    // Only the implemented bits can ever be set; everything else reads 0.
    localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
    localparam logic [31:0] MIE_WMASK     = 32'h0000_0080;

    localparam logic [31:0] MCAUSE_MTI    = 32'h8000_0007;
    // Vectored mode jumps to base + 4*cause, cause 7 = machine timer.
    localparam logic [31:0] MTVEC_MTI_OFS = 32'd28;

    function automatic logic [31:0] csr_apply(input csr_op_e op,
                                              input logic [31:0] old_v,
                                              input logic [31:0] opnd);
        case (op)
            CSR_OP_RS: return old_v | opnd;
            CSR_OP_RC: return old_v & ~opnd;
            default:   return opnd;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// Purpose: 64-bit free-running counter with per-half overwrite (mcycle/minstret).
// Latency: count and writes visible one cycle after the enabling edge.
// Backpressure: none; a write to either half suppresses the increment that cycle.
// Ports: i_inc_en increment request, i_wr_lo/i_wr_hi replace low/high half with
//        i_wdata, o_cnt current 64-bit value.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_inc_en,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [31:0] i_wdata,
    output logic [63:0] o_cnt
);

    logic [63:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 64'd0;
        end else if (i_wr_lo || i_wr_hi) begin
            // Only the written half changes; the other half holds.
            if (i_wr_lo) r_cnt[31:0]  <= i_wdata;
            if (i_wr_hi) r_cnt[63:32] <= i_wdata;
        end else if (i_inc_en) begin
            // Full 64-bit add: carry into the high half lands in the same cycle.
            r_cnt <= r_cnt + 64'd1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/csr_file.sv
// Purpose: machine-mode CSR file with trap CSRs, timer-interrupt entry, mret and 64-bit counters.
// Latency: rdata/illegal_csr/epc combinational; writes and trap effects land on the next edge.
// Backpressure: none; irq_take overrides any same-cycle CSR write and mret.
// Ports: csr_rd/csr_wr/csr_op/addr/wdata CSR access; pc/instr_retired/is_mret/timer_irq
//        from the stage; rdata old value, illegal_csr unmapped access, epc_taken/epc redirect.
module csr_file
    import csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int          XLEN        = 32   // only 32 is supported
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            csr_rd,
    input  logic            csr_wr,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     addr,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] pc,
    input  logic            instr_retired,
    input  logic            is_mret,
    input  logic            timer_irq,
    output logic [XLEN-1:0] rdata,
    output logic            illegal_csr,
    output logic            epc_taken,
    output logic [XLEN-1:0] epc
);

    logic [31:0] r_mstatus;
    logic [31:0] r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic        r_mtip;

    logic [63:0] w_mcycle;
    logic [63:0] w_minstret;
    logic [31:0] w_old;
    logic        w_mapped;
    logic [31:0] w_new;
    logic        w_wr_en;
    logic        w_irq_take;
    logic        w_mret_take;
    logic [31:0] w_tvec_base;

    // Current value of the addressed CSR, independent of csr_rd so that
    // write-only accesses still have an "old" value for RS/RC.
    always_comb begin
        w_old    = 32'd0;
        w_mapped = 1'b1;
        case (addr)
            CSR_MSTATUS:   w_old = r_mstatus;
            CSR_MIE:       w_old = r_mie;
            CSR_MTVEC:     w_old = r_mtvec;
            CSR_MEPC:      w_old = r_mepc;
            CSR_MCAUSE:    w_old = r_mcause;
            CSR_MIP:       w_old = {24'd0, r_mtip, 7'd0};
            CSR_MCYCLE:    w_old = w_mcycle[31:0];
            CSR_MCYCLEH:   w_old = w_mcycle[63:32];
            CSR_MINSTRET:  w_old = w_minstret[31:0];
            CSR_MINSTRETH: w_old = w_minstret[63:32];
            default:       w_mapped = 1'b0;
        endcase
    end

    assign rdata       = (csr_rd && w_mapped) ? w_old : 32'd0;
    assign illegal_csr = (csr_rd || csr_wr) && !w_mapped;

    assign w_irq_take  = r_mstatus[MSTATUS_MIE] & r_mie[MIE_MTIE] & r_mtip & instr_retired;
    assign w_mret_take = is_mret & instr_retired & ~w_irq_take;

    assign w_new   = csr_apply(csr_op_e'(csr_op), w_old, wdata);
    assign w_wr_en = csr_wr && w_mapped && (csr_op_e'(csr_op) != CSR_OP_RSV) && !w_irq_take;

    assign w_tvec_base = {r_mtvec[31:2], 2'b00};

    always_comb begin
        epc_taken = 1'b0;
        epc       = 32'd0;
        if (w_irq_take) begin
            epc_taken = 1'b1;
            epc       = r_mtvec[0] ? (w_tvec_base + MTVEC_MTI_OFS) : w_tvec_base;
        end else if (w_mret_take) begin
            epc_taken = 1'b1;
            epc       = r_mepc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mstatus <= 32'd0;
            r_mie     <= 32'd0;
            r_mtvec   <= MTVEC_RESET & ~32'h2;
            r_mepc    <= 32'd0;
            r_mcause  <= 32'd0;
            r_mtip    <= 1'b0;
        end else begin
            r_mtip <= timer_irq;
            if (w_irq_take) begin
                r_mstatus[MSTATUS_MPIE] <= r_mstatus[MSTATUS_MIE];
                r_mstatus[MSTATUS_MIE]  <= 1'b0;
                r_mepc                  <= pc & ~32'h3;
                r_mcause                <= MCAUSE_MTI;
            end else begin
                if (w_mret_take) begin
                    r_mstatus[MSTATUS_MIE]  <= r_mstatus[MSTATUS_MPIE];
                    r_mstatus[MSTATUS_MPIE] <= 1'b1;
                end else if (w_wr_en && addr == CSR_MSTATUS) begin
                    r_mstatus <= w_new & MSTATUS_WMASK;
                end
                if (w_wr_en && addr == CSR_MIE)    r_mie    <= w_new & MIE_WMASK;
                if (w_wr_en && addr == CSR_MTVEC)  r_mtvec  <= w_new & ~32'h2;
                if (w_wr_en && addr == CSR_MEPC)   r_mepc   <= w_new & ~32'h3;
                if (w_wr_en && addr == CSR_MCAUSE) r_mcause <= w_new;
            end
        end
    end

    csr_counter64 u_mcycle (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_inc_en (1'b1),
        .i_wr_lo  (w_wr_en && addr == CSR_MCYCLE),
        .i_wr_hi  (w_wr_en && addr == CSR_MCYCLEH),
        .i_wdata  (w_new),
        .o_cnt    (w_mcycle)
    );

    // The instruction interrupted by a trap does not retire.
    csr_counter64 u_minstret (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_inc_en (instr_retired & ~w_irq_take),
        .i_wr_lo  (w_wr_en && addr == CSR_MINSTRET),
        .i_wr_hi  (w_wr_en && addr == CSR_MINSTRETH),
        .i_wdata  (w_new),
        .o_cnt    (w_minstret)
    );

endmodule

// File: tb/tb_csr_file.sv
module tb_csr_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        csr_rd, csr_wr;
    logic [1:0]  csr_op;
    logic [11:0] addr;
    logic [31:0] wdata, pc;
    logic        instr_retired, is_mret, timer_irq;
    logic [31:0] rdata, epc;
    logic        illegal_csr, epc_taken;

    always #5 clk = ~clk;

    csr_file #(.MTVEC_RESET(32'h0000_0000), .XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .csr_rd        (csr_rd),
        .csr_wr        (csr_wr),
        .csr_op        (csr_op),
        .addr          (addr),
        .wdata         (wdata),
        .pc            (pc),
        .instr_retired (instr_retired),
        .is_mret       (is_mret),
        .timer_irq     (timer_irq),
        .rdata         (rdata),
        .illegal_csr   (illegal_csr),
        .epc_taken     (epc_taken),
        .epc           (epc)
    );

    int checks = 0;
    int errors = 0;
    bit tirq   = 1'b0;

    // Architectural reference state
    bit        m_mie, m_mpie, m_mtie, m_mtip;
    bit [31:0] m_mtvec, m_mepc, m_mcause;
    bit [63:0] m_cyc, m_ins;

    bit [11:0] addrs [13] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344,
                              12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h7C0, 12'h301, 12'hC00};

    task automatic m_reset();
        m_mie = 0; m_mpie = 0; m_mtie = 0; m_mtip = 0;
        m_mtvec = 32'h0; m_mepc = 0; m_mcause = 0;
        m_cyc = 0; m_ins = 0;
    endtask

    function automatic void m_read(input bit [11:0] a, output bit hit, output bit [31:0] v);
        hit = 1;
        v   = 0;
        case (a)
            12'h300: v = (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h304: v = 32'(m_mtie) << 7;
            12'h305: v = m_mtvec;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h344: v = 32'(m_mtip) << 7;
            12'hB00: v = m_cyc[31:0];
            12'hB80: v = m_cyc[63:32];
            12'hB02: v = m_ins[31:0];
            12'hB82: v = m_ins[63:32];
            default: hit = 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit rd, input bit wr, input bit [1:0] op, input bit [11:0] a,
                         input bit [31:0] wd, input bit [31:0] pc_i, input bit ret, input bit mr);
        csr_rd = rd; csr_wr = wr; csr_op = op; addr = a; wdata = wd;
        pc = pc_i; instr_retired = ret; is_mret = mr; timer_irq = tirq;
    endtask

    // Compare all outputs against the model, advance the model, then clock.
    task automatic tick();
        bit        hit, irq, mr, wr;
        bit [31:0] v, nv, base, e_epc;
        #2;
        m_read(addr, hit, v);
        irq   = m_mie & m_mtie & m_mtip & instr_retired;
        mr    = is_mret & instr_retired & !irq;
        base  = m_mtvec & ~32'h3;
        e_epc = irq ? (m_mtvec[0] ? base + 32'd28 : base) : (mr ? m_mepc : 32'd0);
        chk("rdata", rdata, (csr_rd && hit) ? v : 32'd0);
        chk("illegal", 32'(illegal_csr), 32'((csr_rd || csr_wr) && !hit));
        chk("epc_taken", 32'(epc_taken), 32'(irq || mr));
        chk("epc", epc, e_epc);

        wr = csr_wr && hit && csr_op != 2'd3 && !irq;
        nv = (csr_op == 2'd0) ? wdata : (csr_op == 2'd1) ? (v | wdata) : (v & ~wdata);
        if (wr && addr == 12'hB00)      m_cyc[31:0]  = nv;
        else if (wr && addr == 12'hB80) m_cyc[63:32] = nv;
        else                            m_cyc        = m_cyc + 64'd1;
        if (wr && addr == 12'hB02)      m_ins[31:0]  = nv;
        else if (wr && addr == 12'hB82) m_ins[63:32] = nv;
        else if (instr_retired && !irq) m_ins        = m_ins + 64'd1;
        if (irq) begin
            m_mpie = m_mie; m_mie = 0;
        end else if (mr) begin
            m_mie = m_mpie; m_mpie = 1;
        end else if (wr && addr == 12'h300) begin
            m_mie = nv[3]; m_mpie = nv[7];
        end
        if (wr && addr == 12'h304) m_mtie = nv[7];
        if (wr && addr == 12'h305) m_mtvec = nv & ~32'h2;
        if (irq) begin
            m_mepc = pc & ~32'h3; m_mcause = 32'h8000_0007;
        end else begin
            if (wr && addr == 12'h341) m_mepc = nv & ~32'h3;
            if (wr && addr == 12'h342) m_mcause = nv;
        end
        m_mtip = timer_irq;
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input bit [11:0] a, input bit [31:0] exp, input string tag);
        drive(1, 0, 2'd0, a, 0, 0, 0, 0);
        #2;
        chk(tag, rdata, exp);
        tick();
    endtask

    initial begin
        // Reset
        rst_n = 0;
        drive(1, 0, 2'd0, 12'h305, 0, 0, 0, 0);
        m_reset();
        #12;
        chk("rst_rdata", rdata, 0);
        chk("rst_illegal", 32'(illegal_csr), 0);
        chk("rst_epc_taken", 32'(epc_taken), 0);
        chk("rst_epc", epc, 0);
        @(posedge clk);
        #1;
        rst_n = 1;

        // CSRRW mtvec returns old value, new value visible next cycle
        drive(1, 1, 2'd0, 12'h305, 32'h0000_1001, 0, 0, 0);
        #2;
        chk("rw_old", rdata, 0);
        tick();
        peek(12'h305, 32'h0000_1001, "rw_new");

        // Set / clear MIE, mip read-only
        drive(1, 1, 2'd1, 12'h300, 32'h8, 0, 0, 0);
        tick();
        peek(12'h300, 32'h8, "rs_mstatus");
        drive(1, 1, 2'd2, 12'h300, 32'h8, 0, 0, 0);
        tick();
        peek(12'h300, 32'h0, "rc_mstatus");
        drive(0, 1, 2'd0, 12'h344, 32'hFFFF_FFFF, 0, 0, 0);
        tick();
        peek(12'h344, 32'h0, "mip_ro");

        // Unmapped access
        drive(1, 1, 2'd0, 12'h7C0, 32'hDEAD_BEEF, 0, 0, 0);
        #2;
        chk("ill_flag", 32'(illegal_csr), 1);
        chk("ill_rdata", rdata, 0);
        tick();

        // Direct-mode timer interrupt
        drive(0, 1, 2'd0, 12'h300, 32'h8, 0, 0, 0);   tick();
        drive(0, 1, 2'd0, 12'h304, 32'h80, 0, 0, 0);  tick();
        drive(0, 1, 2'd0, 12'h305, 32'h100, 0, 0, 0); tick();
        tirq = 1;
        peek(12'h344, 32'h0, "mip_latency");
        peek(12'h344, 32'h80, "mip_set");
        drive(0, 0, 2'd0, 12'h000, 0, 32'h200, 1, 0);
        #2;
        chk("irq_taken", 32'(epc_taken), 1);
        chk("irq_epc", epc, 32'h100);
        tick();
        tirq = 0;
        peek(12'h341, 32'h200, "irq_mepc");
        peek(12'h342, 32'h8000_0007, "irq_mcause");
        peek(12'h300, 32'h80, "irq_mstatus");

        // mret
        drive(0, 0, 2'd0, 12'h000, 0, 32'h300, 1, 1);
        #2;
        chk("mret_taken", 32'(epc_taken), 1);
        chk("mret_epc", epc, 32'h200);
        tick();
        peek(12'h300, 32'h88, "mret_mstatus");

        // Vectored-mode timer interrupt
        drive(0, 1, 2'd0, 12'h305, 32'h101, 0, 0, 0); tick();
        tirq = 1;
        peek(12'h305, 32'h101, "mtvec_vec");
        drive(0, 0, 2'd0, 12'h000, 0, 32'h400, 1, 0);
        #2;
        chk("vec_epc", epc, 32'h11C);
        tick();
        tirq = 0;
        peek(12'h341, 32'h400, "vec_mepc");

        // mcycle carry into high half
        drive(0, 1, 2'd0, 12'hB80, 0, 0, 0, 0);            tick();
        drive(0, 1, 2'd0, 12'hB00, 32'hFFFF_FFFF, 0, 0, 0); tick();
        peek(12'hB00, 32'hFFFF_FFFF, "cyc_written");
        drive(1, 0, 2'd0, 12'hB00, 0, 0, 0, 0);
        #2;
        chk("cyc_wrap_lo", rdata, 0);
        addr = 12'hB80;
        #1;
        chk("cyc_wrap_hi", rdata, 1);
        tick();

        // Async reset mid-run clears counters immediately
        drive(1, 0, 2'd0, 12'hB00, 0, 0, 0, 0);
        rst_n = 0;
        #2;
        chk("arst_mcycle", rdata, 0);
        addr = 12'hB02;
        #1;
        chk("arst_minstret", rdata, 0);
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1;

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            bit [31:0] wd;
            tirq = ($urandom_range(0, 2) == 0);
            wd = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  addrs[$urandom_range(0, 12)], wd, $urandom,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR unit sitting beside the integer register file in the execute/writeback stage.
- Consumes the rs1 operand (or zero-extended zimm) read from the register file for CSRRW/CSRRS/CSRRC.
- Returns the old CSR value as writeback data toward reg_file.wdata.
- Owns the machine trap CSRs and 64-bit cycle/instret counters; redirects PC on timer-interrupt entry and on mret.

Parameters:
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec.
- XLEN, 32, data width; only 32 is supported.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset; clears all state immediately.
- csr_rd  input  1  CSR instruction reads addr this cycle.
- csr_wr  input  1  CSR instruction writes addr this cycle.
- csr_op  input  2  00 = RW, 01 = RS (set bits), 10 = RC (clear bits), 11 = reserved (treated as no write).
- addr  input  12  CSR address from instr[31:20].
- wdata  input  32  operand: rs1 value, or zero-extended zimm.
- pc  input  32  PC of the instruction currently in this stage.
- instr_retired  input  1  instruction in this stage commits this cycle.
- is_mret  input  1  decoded mret in this stage.
- timer_irq  input  1  level machine-timer interrupt request.
- rdata  output  32  old CSR value; combinational.
- illegal_csr  output  1  csr_rd or csr_wr targets an unmapped address; combinational.
- epc_taken  output  1  PC redirect this cycle.
- epc  output  32  redirect target.

Behaviour:
- Address map:
  - 0x300 mstatus: only MIE[3] and MPIE[7] implemented; other bits read 0.
  - 0x304 mie: only MTIE[7] implemented.
  - 0x305 mtvec: bit1 reads 0.
  - 0x341 mepc: [1:0] forced 0.
  - 0x342 mcause.
  - 0x344 mip: read-only; MTIP[7] = registered timer_irq.
  - 0xB00 mcycle, 0xB80 mcycleh, 0xB02 minstret, 0xB82 minstreth.
- Read path:
  - rdata is combinational from addr and current state; zero-cycle latency.
  - rdata = 0 when csr_rd = 0 or the address is unmapped.
- Write path:
  - New value = wdata (RW), old | wdata (RS), or old & ~wdata (RC).
  - New value is committed on the next rising edge and visible on rdata the following cycle.
  - Read-modify-write returns the pre-write value on rdata.
- Illegal access:
  - illegal_csr = (csr_rd | csr_wr) & unmapped addr.
  - No state change on an illegal access.
  - Writes to mip are silently ignored (not illegal).
- mip.MTIP is sampled from timer_irq every cycle: 1-cycle latency.
- Interrupt take, irq_take = mstatus.MIE & mie.MTIE & mip.MTIP & instr_retired:
  - epc_taken = 1.
  - epc = {mtvec[31:2],2'b00} in direct mode (mtvec[0]=0), or base + 28 in vectored mode.
  - Next edge: mepc <= pc, mcause <= 32'h8000_0007, MPIE <= MIE, MIE <= 0.
- mret (is_mret & instr_retired & ~irq_take):
  - epc_taken = 1, epc = mepc.
  - Next edge: MIE <= MPIE, MPIE <= 1.
- Priority on simultaneous events:
  - irq_take suppresses any same-cycle CSR write and any mret update.
  - The interrupted instruction does not count in minstret.
- Counters:
  - mcycle (64-bit) increments every cycle.
  - minstret increments when instr_retired & ~irq_take.
  - Carry from the low 32 bits into the high half is taken in the same cycle.
  - A CSR write to either half in a cycle replaces that half only; that counter does not increment in that cycle.
  - Wrap from all-ones to 0 without flag.
- Reset (async, rst_n = 0):
  - All CSRs and counters become 0, except mtvec = MTIP_RESET... mtvec = MTVEC_RESET.
  - Outputs are therefore rdata = 0, illegal_csr = 0, epc_taken = 0, epc = 0.
  - Reset asserted mid-operation discards any pending write.
- epc = 0 whenever epc_taken = 0.

Decomposition:
- Shared package csr_pkg:
  - CSR address localparams.
  - csr_op_e enum (RW/RS/RC).
  - Bit-index constants: MIE = 3, MPIE = 7, MTIE/MTIP = 7.
  - MCAUSE_MTI = 32'h8000_0007.
- One sub-module, csr_counter64: 64-bit counter with an increment enable and per-half write enables; instantiated for mcycle and minstret.

Test Plan:
- Reset then CSRRW 0x305 wdata = 0x0000_1001 -> rdata = 0 that cycle; next read of 0x305 = 0x0000_1001.
- CSRRS 0x300 wdata = 0x8, then CSRRC 0x300 wdata = 0x8 -> reads 0x8, then 0x0; write to 0x344 leaves mip unchanged.
- Read of 0x7C0 with csr_rd = 1 -> illegal_csr = 1, rdata = 0, no state change.
- MIE = 1, MTIE = 1, mtvec = 0x100, timer_irq = 1, instr_retired at pc = 0x200 -> epc_taken = 1, epc = 0x100; then mepc = 0x200, mcause = 0x8000_0007, mstatus = 0x80.
- mret after the interrupt -> epc_taken = 1, epc = 0x200, mstatus = 0x88. Repeat with mtvec = 0x101 -> interrupt epc = 0x11C.
- Write mcycle = 0xFFFF_FFFF, then read mcycle/mcycleh over the next cycles -> low half wraps to 0, mcycleh = 1; rst_n pulse mid-sequence -> both counters 0 immediately.
